// File: rtl/if_fetch_stage_pkg.sv
// Shared types and constants for the instruction fetch stage.
package if_pkg;

  localparam int unsigned IF_XLEN   = 32;
  localparam int unsigned PC_STEP   = 4;
  localparam logic [IF_XLEN-1:0] NOP_INSTR = 32'h0000_0013;

  typedef enum logic [1:0] {
    BOOT  = 2'd0,
    FETCH = 2'd1,
    HOLD  = 2'd2
  } if_state_t;

  // One prefetched instruction together with the PC it was fetched from
  typedef struct packed {
    logic [IF_XLEN-1:0] pc;
    logic [IF_XLEN-1:0] instr;
  } if_entry_t;

endpackage

// File: rtl/if_fetch_stage_fifo.sv
// Prefetch FIFO of if_entry_t with flush, occupancy count and a registered head.
module if_fifo
  import if_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         i_flush,
  input  logic                         i_push,
  input  if_entry_t                    i_data,
  input  logic                         i_pop,
  output logic                         o_valid,
  output if_entry_t                    o_head,
  output logic [$clog2(DEPTH+1)-1:0]   o_count
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = $clog2(DEPTH+1);

  if_entry_t       r_mem [DEPTH];
  logic [AW-1:0]   r_wr;
  logic [AW-1:0]   r_rd;
  logic [CW-1:0]   r_count;
  logic            r_valid;
  if_entry_t       r_head;

  logic            w_push;
  logic            w_pop;
  logic            w_full;
  logic            w_empty;
  logic [AW-1:0]   w_rd_nxt;
  logic [CW-1:0]   w_count_nxt;
  if_entry_t       w_head_nxt;

  // Qualified push/pop and next pointer/count/head values
  always_comb begin
    w_full      = (r_count == CW'(DEPTH));
    w_empty     = (r_count == '0);
    w_push      = i_push & ~i_flush;
    w_pop       = i_pop & ~i_flush & ~w_empty;
    w_rd_nxt    = r_rd + AW'(w_pop);
    w_count_nxt = r_count + CW'(w_push) - CW'(w_pop);
    // New word becomes head only when nothing older remains after this pop
    if (w_push && (r_wr == w_rd_nxt)) begin
      w_head_nxt = i_data;
    end else begin
      w_head_nxt = r_mem[w_rd_nxt];
    end
  end

  // Storage array, write side only
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr] <= i_data;
    end
  end

  // Pointers, count and the registered head presented downstream
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr    <= '0;
      r_rd    <= '0;
      r_count <= '0;
      r_valid <= 1'b0;
      r_head  <= '0;
    end else if (i_flush) begin
      r_wr    <= '0;
      r_rd    <= '0;
      r_count <= '0;
      r_valid <= 1'b0;
    end else begin
      r_wr    <= r_wr + AW'(w_push);
      r_rd    <= w_rd_nxt;
      r_count <= w_count_nxt;
      r_valid <= (w_count_nxt != '0);
      r_head  <= w_head_nxt;
    end
  end

  // A push into a full FIFO means the upstream issue throttle is broken
  always_ff @(posedge clk) begin
    if (!rst) begin
      assert (!(w_push && w_full));
    end
  end

  assign o_valid = r_valid;
  assign o_head  = r_head;
  assign o_count = r_count;

endmodule

// File: rtl/if_fetch_stage.sv
// Instruction fetch stage: owns the PC, issues in-order imem requests,
// buffers tagged responses and hands them downstream over valid/ready.
// Optional macro IF_FETCH_PERF_EN adds fetch_count_o (delivered instructions).
module if_fetch_stage
  import if_pkg::*;
#(
  parameter int unsigned      XLEN       = IF_XLEN,
  parameter logic [XLEN-1:0]  RESET_PC   = '0,
  parameter int unsigned      FIFO_DEPTH = 4,
  parameter int unsigned      MAX_OUTST  = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             redirect_i,
  input  logic [XLEN-1:0]  redirect_pc_i,
  input  logic             halt_i,
  output logic             imem_req_o,
  output logic [XLEN-1:0]  imem_addr_o,
  input  logic             imem_gnt_i,
  input  logic             imem_rvalid_i,
  input  logic [XLEN-1:0]  imem_rdata_i,
  output logic             out_valid_o,
  input  logic             out_ready_i,
  output logic [XLEN-1:0]  out_instr_o,
  output logic [XLEN-1:0]  out_pc_o
`ifdef IF_FETCH_PERF_EN
  ,
  output logic [31:0]      fetch_count_o
`endif
);

  localparam int unsigned CW = $clog2(FIFO_DEPTH+1);

  if_state_t        r_state;
  if_state_t        w_state_nxt;
  logic [XLEN-1:0]  r_pc;
  logic [XLEN-1:0]  r_resp_pc;
  logic [CW-1:0]    r_outst;
  logic [CW-1:0]    r_discard;

  logic [XLEN-1:0]  w_target;
  logic [CW-1:0]    w_count;
  logic [CW:0]      w_inflight;
  logic             w_issue;
  logic             w_push;
  logic             w_pop;
  if_entry_t        w_push_data;
  if_entry_t        w_head;

  assign w_target    = redirect_pc_i & ~XLEN'(3);
  assign w_issue     = imem_req_o & imem_gnt_i;
  assign w_push      = imem_rvalid_i & ~redirect_i & (r_discard == '0);
  assign w_pop       = out_valid_o & out_ready_i & ~redirect_i;
  assign w_push_data = '{pc: r_resp_pc, instr: imem_rdata_i};

  // FSM state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= BOOT;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // FSM next state: halt parks the fetcher in HOLD
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      BOOT:    w_state_nxt = halt_i ? HOLD : FETCH;
      FETCH:   if (halt_i)  w_state_nxt = HOLD;
      HOLD:    if (!halt_i) w_state_nxt = FETCH;
      default: w_state_nxt = BOOT;
    endcase
  end

  // FSM output: request only when FIFO space covers every in-flight word
  always_comb begin
    imem_req_o = 1'b0;
    w_inflight = (CW+1)'(w_count) + (CW+1)'(r_outst);
    if ((r_state == FETCH) && !redirect_i &&
        (r_outst < CW'(MAX_OUTST)) && (w_inflight < (CW+1)'(FIFO_DEPTH))) begin
      imem_req_o = 1'b1;
    end
  end

  // PC, response PC and outstanding/discard bookkeeping; redirect wins
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_pc      <= RESET_PC;
      r_resp_pc <= RESET_PC;
      r_outst   <= '0;
      r_discard <= '0;
    end else if (redirect_i) begin
      r_pc      <= w_target;
      r_resp_pc <= w_target;
      r_outst   <= r_outst - CW'(imem_rvalid_i);
      r_discard <= r_outst - CW'(imem_rvalid_i);
    end else begin
      if (w_issue) begin
        r_pc <= r_pc + XLEN'(PC_STEP);
      end
      r_outst <= r_outst + CW'(w_issue) - CW'(imem_rvalid_i);
      if (imem_rvalid_i) begin
        if (r_discard != '0) begin
          r_discard <= r_discard - CW'(1);
        end else begin
          r_resp_pc <= r_resp_pc + XLEN'(PC_STEP);
        end
      end
    end
  end

  if_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .i_flush (redirect_i),
    .i_push  (w_push),
    .i_data  (w_push_data),
    .i_pop   (w_pop),
    .o_valid (out_valid_o),
    .o_head  (w_head),
    .o_count (w_count)
  );

  assign imem_addr_o = r_pc;
  assign out_instr_o = w_head.instr;
  assign out_pc_o    = w_head.pc;

`ifdef IF_FETCH_PERF_EN
  logic [31:0] r_fetch_count;

  // Delivered-instruction counter, survives redirects
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_fetch_count <= '0;
    end else if (w_pop) begin
      r_fetch_count <= r_fetch_count + 32'd1;
    end
  end

  assign fetch_count_o = r_fetch_count;
`endif

endmodule

// File: tb/tb_if_fetch_stage.sv
// Scoreboard bench for if_fetch_stage with an in-order imem responder.
module tb_if_fetch_stage;
  import if_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        redirect_i = 1'b0;
  logic [31:0] redirect_pc_i = '0;
  logic        halt_i = 1'b0;
  logic        imem_req_o;
  logic [31:0] imem_addr_o;
  logic        imem_gnt_i = 1'b0;
  logic        imem_rvalid_i = 1'b0;
  logic [31:0] imem_rdata_i = '0;
  logic        out_valid_o;
  logic        out_ready_i = 1'b0;
  logic [31:0] out_instr_o;
  logic [31:0] out_pc_o;
`ifdef IF_FETCH_PERF_EN
  logic [31:0] fetch_count_o;
`endif

  always #5 clk = ~clk;

  if_fetch_stage dut (
    .clk           (clk),
    .rst           (rst),
    .redirect_i    (redirect_i),
    .redirect_pc_i (redirect_pc_i),
    .halt_i        (halt_i),
    .imem_req_o    (imem_req_o),
    .imem_addr_o   (imem_addr_o),
    .imem_gnt_i    (imem_gnt_i),
    .imem_rvalid_i (imem_rvalid_i),
    .imem_rdata_i  (imem_rdata_i),
    .out_valid_o   (out_valid_o),
    .out_ready_i   (out_ready_i),
    .out_instr_o   (out_instr_o),
    .out_pc_o      (out_pc_o)
`ifdef IF_FETCH_PERF_EN
    ,
    .fetch_count_o (fetch_count_o)
`endif
  );

  typedef struct {
    logic [31:0] addr;
    int          epoch;
    int          due;
  } req_t;

  int          errors = 0;
  int          checks = 0;
  req_t        rq[$];
  if_entry_t   sb[$];
  int          cyc, epoch, lat;
  int          n_req, n_pop, first_req_cyc, first_valid_cyc;
  logic [31:0] exp_addr, last_addr, last_pop_pc, first_pop_pc;
  bit          cap_first, prev_halt;
  logic        drv_redirect, drv_halt, drv_ready, drv_gnt;
  logic [31:0] drv_target;

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  function automatic logic [31:0] instr_of(input logic [31:0] a);
    return a ^ 32'h5A5A_0013;
  endfunction

  // Asynchronous reset: outputs must take reset values before any clock edge
  task automatic do_reset();
    @(negedge clk);
    #2;
    rst = 1'b1;
    #1;
    check_eq("rst_req", {31'd0, imem_req_o}, 32'd0);
    check_eq("rst_addr", imem_addr_o, 32'h0);
    check_eq("rst_valid", {31'd0, out_valid_o}, 32'd0);
    check_eq("rst_instr", out_instr_o, 32'h0);
    check_eq("rst_pc", out_pc_o, 32'h0);
`ifdef IF_FETCH_PERF_EN
    check_eq("rst_fetch_count", fetch_count_o, 32'd0);
`endif
    redirect_i = 0; halt_i = 0; imem_gnt_i = 0; imem_rvalid_i = 0; imem_rdata_i = '0;
    out_ready_i = 0;
    drv_redirect = 0; drv_target = '0; drv_halt = 0; drv_ready = 1; drv_gnt = 1;
    rq.delete(); sb.delete();
    epoch = 0; exp_addr = 32'h0; lat = 1;
    n_req = 0; n_pop = 0; first_req_cyc = -1; first_valid_cyc = -1;
    last_addr = '0; last_pop_pc = '0; first_pop_pc = 32'hFFFF_FFFF; cap_first = 0; prev_halt = 0;
    @(negedge clk);
    rst = 1'b0;
    cyc = 0;
  endtask

  // One cycle: drive at negedge, settle, then observe what the next posedge will take
  task automatic step();
    req_t r;
    if_entry_t e;
    bit rv;
    @(negedge clk);
    cyc++;
    redirect_i    = drv_redirect;
    redirect_pc_i = drv_target;
    halt_i        = drv_halt;
    out_ready_i   = drv_ready;
    imem_gnt_i    = drv_gnt;
    rv = (rq.size() > 0) && (rq[0].due <= cyc);
    imem_rvalid_i = rv;
    imem_rdata_i  = rv ? instr_of(rq[0].addr) : 32'h0;
    #1;
    check_eq("out_valid", {31'd0, out_valid_o}, {31'd0, sb.size() != 0});
`ifdef IF_FETCH_PERF_EN
    check_eq("fetch_count", fetch_count_o, 32'(n_pop));
`endif
    if (redirect_i) check_eq("req_on_redirect", {31'd0, imem_req_o}, 32'd0);
    if (prev_halt && halt_i) check_eq("req_in_hold", {31'd0, imem_req_o}, 32'd0);
    if (out_valid_o && out_ready_i && !redirect_i) begin
      if (first_valid_cyc < 0) first_valid_cyc = cyc;
      if (sb.size() == 0) begin
        check_eq("pop_has_expected", 32'(sb.size()), 32'd1);
      end else begin
        e = sb.pop_front();
        check_eq("pop_pc", out_pc_o, e.pc);
        check_eq("pop_instr", out_instr_o, e.instr);
      end
      n_pop++;
      last_pop_pc = out_pc_o;
      if (cap_first) begin
        first_pop_pc = out_pc_o;
        cap_first = 0;
      end
    end
    if (rv) begin
      r = rq.pop_front();
      if (r.epoch == epoch && !redirect_i) sb.push_back('{pc: r.addr, instr: instr_of(r.addr)});
    end
    if (imem_req_o && imem_gnt_i) begin
      check_eq("req_addr", imem_addr_o, exp_addr);
      rq.push_back('{addr: exp_addr, epoch: epoch, due: cyc + lat});
      last_addr = exp_addr;
      exp_addr += 32'd4;
      n_req++;
      if (first_req_cyc < 0) first_req_cyc = cyc;
    end
    if (redirect_i) begin
      sb.delete();
      epoch++;
      exp_addr = redirect_pc_i & 32'hFFFF_FFFC;
    end
    prev_halt = halt_i;
  endtask

  initial begin
    int saved_req, saved_pop;
    logic [31:0] saved_addr;

    // 1: streaming fetch with 1-cycle memory
    do_reset();
    repeat (12) step();
    check_eq("t1_first_req_cyc", 32'(first_req_cyc), 32'd1);
    check_eq("t1_first_valid_cyc", 32'(first_valid_cyc), 32'd3);
    check_eq("t1_pops", 32'(n_pop), 32'd10);
    check_eq("t1_last_pop_pc", last_pop_pc, 32'h24);

    // 2: stalled consumer fills FIFO, then drains and fetch resumes at 16
    do_reset();
    drv_ready = 0;
    repeat (20) step();
    check_eq("t2_reqs_stalled", 32'(n_req), 32'd4);
    check_eq("t2_req_low_full", {31'd0, imem_req_o}, 32'd0);
    check_eq("t2_sb_depth", 32'(sb.size()), 32'd4);
    drv_ready = 1;
    cap_first = 1;
    repeat (8) step();
    check_eq("t2_first_pop_pc", first_pop_pc, 32'h0);
    check_eq("t2_resumed", {31'd0, n_req > 4}, 32'd1);
    check_eq("t2_drained", {31'd0, n_pop >= 4}, 32'd1);

    // 3: redirect with two outstanding requests
    do_reset();
    lat = 3;
    for (int i = 0; i < 10 && rq.size() < 2; i++) step();
    check_eq("t3_outst_setup", 32'(rq.size()), 32'd2);
    drv_redirect = 1; drv_target = 32'h100;
    step();
    drv_redirect = 0;
    cap_first = 1;
    repeat (14) step();
    check_eq("t3_first_pop_pc", first_pop_pc, 32'h100);

    // 4: misaligned redirect target is word-aligned
    do_reset();
    repeat (6) step();
    drv_redirect = 1; drv_target = 32'h203;
    step();
    drv_redirect = 0;
    cap_first = 1;
    saved_req = n_req;
    step();
    check_eq("t4_req_after_redirect", 32'(n_req - saved_req), 32'd1);
    check_eq("t4_addr", last_addr, 32'h200);
    repeat (6) step();
    check_eq("t4_first_pop_pc", first_pop_pc, 32'h200);

    // 5: halt with two outstanding, responses still delivered
    do_reset();
    lat = 3;
    for (int i = 0; i < 10 && rq.size() < 2; i++) step();
    check_eq("t5_outst_setup", 32'(rq.size()), 32'd2);
    drv_halt = 1;
    saved_req = n_req; saved_pop = n_pop; saved_addr = last_addr;
    repeat (10) step();
    check_eq("t5_no_new_req", 32'(n_req), 32'(saved_req));
    check_eq("t5_delivered", 32'(n_pop - saved_pop), 32'd2);
    check_eq("t5_sb_empty", 32'(sb.size()), 32'd0);
    drv_halt = 0;
    for (int i = 0; i < 10 && n_req == saved_req; i++) step();
    check_eq("t5_resume_addr", last_addr, saved_addr + 32'd4);

`ifdef IF_FETCH_PERF_EN
    // 6: pop counter unaffected by redirect
    do_reset();
    for (int i = 0; i < 40 && n_pop < 10; i++) step();
    drv_ready = 0;
    drv_redirect = 1; drv_target = 32'h400;
    step();
    drv_redirect = 0;
    step();
    check_eq("t6_count_after_redirect", fetch_count_o, 32'd10);
    repeat (3) step();
    check_eq("t6_count_held", fetch_count_o, 32'd10);
`endif

    // Reset in the middle of a burst
    drv_ready = 1;
    repeat (5) step();
    do_reset();
    repeat (4) step();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
